// File: rtl/global_defs.sv
// Shared integer-pipeline types: ROB tags, register data, addresses and the
// issue-queue entry layout used by dispatch, the IIQ and the ALU.
`ifndef GLOBAL_DEFS_SV
`define GLOBAL_DEFS_SV
`define ROB_ID_WIDTH 5
`define REG_DATA_WIDTH 32

package global_defs;
  localparam int unsigned ADDR_WIDTH = 32;

  typedef logic [`ROB_ID_WIDTH-1:0]   rob_id_t;
  typedef logic [`REG_DATA_WIDTH-1:0] reg_data_t;
  typedef logic [ADDR_WIDTH-1:0]      addr_t;

  typedef struct packed {
    addr_t     pc;
    logic [3:0] alu_op;
    rob_id_t   instr_rob_id;
    logic      dst_valid;
    logic      src1_valid;
    logic      src1_ready;
    rob_id_t   src1_rob_id;
    reg_data_t src1_data;
    logic      src2_valid;
    logic      src2_ready;
    rob_id_t   src2_rob_id;
    reg_data_t src2_data;
  } iiq_entry_t;

  // A broadcast only matters to a source that actually reads a register.
  function automatic logic tag_hit(input logic bcast_valid, input rob_id_t bcast_tag,
                                   input logic src_valid, input rob_id_t src_tag);
    return bcast_valid & src_valid & (bcast_tag == src_tag);
  endfunction
endpackage
`endif

// File: rtl/int_issue_queue_select.sv
// Find-first selector: lowest-index requester wins (slot 0 is the oldest).
module iiq_select #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !any) begin
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue: compacting age-ordered buffer that tracks source
// readiness, captures broadcast data and issues the oldest ready entry.
module int_issue_queue
  import global_defs::*;
#(
  parameter int unsigned N_ENTRIES = 8,
  parameter int unsigned CNT_WIDTH = $clog2(N_ENTRIES) + 1
) (
  input  logic       clk,
  input  logic       rst_aL,
  output logic       iiq_dispatch_ready,
  input  logic       iiq_dispatch_valid,
  input  iiq_entry_t iiq_dispatch_data,
  input  logic       alu_issue_ready,
  output logic       iiq_issue_valid,
  output iiq_entry_t iiq_issue_data,
  output logic       iiq_wakeup_valid,
  output rob_id_t    iiq_wakeup_rob_id,
  input  logic       alu_broadcast_valid,
  input  rob_id_t    alu_broadcast_rob_id,
  input  reg_data_t  alu_broadcast_reg_data,
  input  logic       ld_broadcast_valid,
  input  rob_id_t    ld_broadcast_rob_id,
  input  reg_data_t  ld_broadcast_reg_data,
  input  logic       fetch_redirect_valid
);
  localparam int unsigned IDX_W = $clog2(N_ENTRIES);

  iiq_entry_t entries     [N_ENTRIES];
  iiq_entry_t entries_upd [N_ENTRIES];
  iiq_entry_t entries_nxt [N_ENTRIES];
  logic [N_ENTRIES-1:0] valid, valid_nxt, ready_vec, sel_grant;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_any;
  logic [CNT_WIDTH-1:0] count, count_nxt, wr_slot;
  logic                 issue_fire, dispatch_fire;
  iiq_entry_t           sel_entry, bypassed;

  always_comb begin
    ready_vec = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++)
      ready_vec[i] = valid[i] & (~entries[i].src1_valid | entries[i].src1_ready)
                              & (~entries[i].src2_valid | entries[i].src2_ready);
  end

  iiq_select #(.N(N_ENTRIES), .IDX_W(IDX_W)) u_select (
    .req   (ready_vec),
    .grant (sel_grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign iiq_dispatch_ready = (count < CNT_WIDTH'(N_ENTRIES));
  assign iiq_issue_valid    = sel_any & ~fetch_redirect_valid;
  assign issue_fire         = iiq_issue_valid & alu_issue_ready;
  assign dispatch_fire      = iiq_dispatch_valid & iiq_dispatch_ready & ~fetch_redirect_valid;
  assign iiq_wakeup_valid   = issue_fire & sel_entry.dst_valid;
  assign iiq_wakeup_rob_id  = iiq_wakeup_valid ? sel_entry.instr_rob_id : '0;
  assign wr_slot            = count - CNT_WIDTH'(issue_fire);

  // One-hot mux of the granted slot, then same-cycle ALU/load data bypass.
  always_comb begin
    sel_entry = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++)
      if (sel_grant[i]) sel_entry = iiq_entry_t'(sel_entry | entries[i]);
    bypassed = sel_entry;
    if (tag_hit(alu_broadcast_valid, alu_broadcast_rob_id, sel_entry.src1_valid, sel_entry.src1_rob_id))
      bypassed.src1_data = alu_broadcast_reg_data;
    else if (tag_hit(ld_broadcast_valid, ld_broadcast_rob_id, sel_entry.src1_valid, sel_entry.src1_rob_id))
      bypassed.src1_data = ld_broadcast_reg_data;
    if (tag_hit(alu_broadcast_valid, alu_broadcast_rob_id, sel_entry.src2_valid, sel_entry.src2_rob_id))
      bypassed.src2_data = alu_broadcast_reg_data;
    else if (tag_hit(ld_broadcast_valid, ld_broadcast_rob_id, sel_entry.src2_valid, sel_entry.src2_rob_id))
      bypassed.src2_data = ld_broadcast_reg_data;
    iiq_issue_data = iiq_issue_valid ? bypassed : '0;
  end

  // Wakeup/capture are applied before the collapse so shifted entries keep them.
  always_comb begin
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      entries_upd[i] = entries[i];
      if (tag_hit(iiq_wakeup_valid, iiq_wakeup_rob_id, entries[i].src1_valid, entries[i].src1_rob_id))
        entries_upd[i].src1_ready = 1'b1;
      if (tag_hit(iiq_wakeup_valid, iiq_wakeup_rob_id, entries[i].src2_valid, entries[i].src2_rob_id))
        entries_upd[i].src2_ready = 1'b1;
      if (tag_hit(alu_broadcast_valid, alu_broadcast_rob_id, entries[i].src1_valid, entries[i].src1_rob_id))
        entries_upd[i].src1_data = alu_broadcast_reg_data;
      else if (tag_hit(ld_broadcast_valid, ld_broadcast_rob_id, entries[i].src1_valid, entries[i].src1_rob_id)) begin
        entries_upd[i].src1_data  = ld_broadcast_reg_data;
        entries_upd[i].src1_ready = 1'b1;
      end
      if (tag_hit(alu_broadcast_valid, alu_broadcast_rob_id, entries[i].src2_valid, entries[i].src2_rob_id))
        entries_upd[i].src2_data = alu_broadcast_reg_data;
      else if (tag_hit(ld_broadcast_valid, ld_broadcast_rob_id, entries[i].src2_valid, entries[i].src2_rob_id)) begin
        entries_upd[i].src2_data  = ld_broadcast_reg_data;
        entries_upd[i].src2_ready = 1'b1;
      end
    end

    valid_nxt = valid;
    for (int unsigned i = 0; i < N_ENTRIES - 1; i++) begin
      if (issue_fire && (IDX_W'(i) >= sel_idx)) begin
        entries_nxt[i] = entries_upd[i+1];
        valid_nxt[i]   = valid[i+1];
      end else begin
        entries_nxt[i] = entries_upd[i];
      end
    end
    entries_nxt[N_ENTRIES-1] = entries_upd[N_ENTRIES-1];
    if (issue_fire) valid_nxt[N_ENTRIES-1] = 1'b0;

    if (dispatch_fire) begin
      entries_nxt[wr_slot[IDX_W-1:0]] = iiq_dispatch_data;
      valid_nxt[wr_slot[IDX_W-1:0]]   = 1'b1;
    end
    if (fetch_redirect_valid) valid_nxt = '0;

    count_nxt = fetch_redirect_valid ? '0
              : count - CNT_WIDTH'(issue_fire) + CNT_WIDTH'(dispatch_fire);
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      valid <= '0;
      count <= '0;
    end else begin
      valid <= valid_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_ENTRIES; i++) entries[i] <= entries_nxt[i];
  end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed self-checking bench for int_issue_queue: issue, dependence bypass,
// age order, load wakeup, flush and asynchronous reset.
module tb_int_issue_queue;
  import global_defs::*;

  logic       clk;
  logic       rst_aL;
  logic       iiq_dispatch_ready;
  logic       iiq_dispatch_valid;
  iiq_entry_t iiq_dispatch_data;
  logic       alu_issue_ready;
  logic       iiq_issue_valid;
  iiq_entry_t iiq_issue_data;
  logic       iiq_wakeup_valid;
  rob_id_t    iiq_wakeup_rob_id;
  logic       alu_broadcast_valid;
  rob_id_t    alu_broadcast_rob_id;
  reg_data_t  alu_broadcast_reg_data;
  logic       ld_broadcast_valid;
  rob_id_t    ld_broadcast_rob_id;
  reg_data_t  ld_broadcast_reg_data;
  logic       fetch_redirect_valid;

  int n_tests;
  int n_fail;

  int_issue_queue #(.N_ENTRIES(8)) dut (
    .clk                    (clk),
    .rst_aL                 (rst_aL),
    .iiq_dispatch_ready     (iiq_dispatch_ready),
    .iiq_dispatch_valid     (iiq_dispatch_valid),
    .iiq_dispatch_data      (iiq_dispatch_data),
    .alu_issue_ready        (alu_issue_ready),
    .iiq_issue_valid        (iiq_issue_valid),
    .iiq_issue_data         (iiq_issue_data),
    .iiq_wakeup_valid       (iiq_wakeup_valid),
    .iiq_wakeup_rob_id      (iiq_wakeup_rob_id),
    .alu_broadcast_valid    (alu_broadcast_valid),
    .alu_broadcast_rob_id   (alu_broadcast_rob_id),
    .alu_broadcast_reg_data (alu_broadcast_reg_data),
    .ld_broadcast_valid     (ld_broadcast_valid),
    .ld_broadcast_rob_id    (ld_broadcast_rob_id),
    .ld_broadcast_reg_data  (ld_broadcast_reg_data),
    .fetch_redirect_valid   (fetch_redirect_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic iiq_entry_t mk(input int rob, input logic dst,
                                    input logic s1v, input logic s1r, input int s1rob, input int s1d,
                                    input logic s2v, input logic s2r, input int s2rob, input int s2d);
    iiq_entry_t e;
    e = '0;
    e.pc           = addr_t'(32'h1000 + rob * 4);
    e.instr_rob_id = rob_id_t'(rob);
    e.dst_valid    = dst;
    e.src1_valid   = s1v;
    e.src1_ready   = s1r;
    e.src1_rob_id  = rob_id_t'(s1rob);
    e.src1_data    = reg_data_t'(s1d);
    e.src2_valid   = s2v;
    e.src2_ready   = s2r;
    e.src2_rob_id  = rob_id_t'(s2rob);
    e.src2_data    = reg_data_t'(s2d);
    return e;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_aL = 1'b0;
    iiq_dispatch_valid = 1'b0;
    iiq_dispatch_data = '0;
    alu_issue_ready = 1'b0;
    alu_broadcast_valid = 1'b0;
    alu_broadcast_rob_id = '0;
    alu_broadcast_reg_data = '0;
    ld_broadcast_valid = 1'b0;
    ld_broadcast_rob_id = '0;
    ld_broadcast_reg_data = '0;
    fetch_redirect_valid = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_dispatch_ready", 64'(iiq_dispatch_ready), 64'd1);
    chk("rst_issue_valid", 64'(iiq_issue_valid), 64'd0);
    chk("rst_wakeup_valid", 64'(iiq_wakeup_valid), 64'd0);
    chk("rst_issue_data_zero", 64'(iiq_issue_data == '0), 64'd1);
    chk("rst_wakeup_rob", 64'(iiq_wakeup_rob_id), 64'd0);
    nxt();
    rst_aL = 1'b1;

    // basic issue
    iiq_dispatch_valid = 1'b1;
    iiq_dispatch_data = mk(3, 1, 1, 1, 0, 5, 0, 0, 0, 0);
    alu_issue_ready = 1'b1;
    @(negedge clk);
    chk("basic_no_issue_yet", 64'(iiq_issue_valid), 64'd0);
    nxt();
    iiq_dispatch_valid = 1'b0;
    @(negedge clk);
    chk("basic_issue_valid", 64'(iiq_issue_valid), 64'd1);
    chk("basic_issue_rob", 64'(iiq_issue_data.instr_rob_id), 64'd3);
    chk("basic_src1_data", 64'(iiq_issue_data.src1_data), 64'd5);
    chk("basic_wakeup_valid", 64'(iiq_wakeup_valid), 64'd1);
    chk("basic_wakeup_rob", 64'(iiq_wakeup_rob_id), 64'd3);
    nxt();
    @(negedge clk);
    chk("basic_drained_valid", 64'(iiq_issue_valid), 64'd0);
    chk("basic_drained_ready", 64'(iiq_dispatch_ready), 64'd1);
    chk("basic_count_zero", 64'(dut.count), 64'd0);

    // back-to-back dependence through ALU bypass
    nxt();
    alu_issue_ready = 1'b0;
    iiq_dispatch_valid = 1'b1;
    iiq_dispatch_data = mk(2, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    nxt();
    iiq_dispatch_data = mk(4, 1, 1, 0, 2, 0, 0, 0, 0, 0);
    nxt();
    iiq_dispatch_valid = 1'b0;
    alu_issue_ready = 1'b1;
    @(negedge clk);
    chk("dep_a_issue_rob", 64'(iiq_issue_data.instr_rob_id), 64'd2);
    chk("dep_a_wakeup_rob", 64'(iiq_wakeup_rob_id), 64'd2);
    nxt();
    alu_broadcast_valid = 1'b1;
    alu_broadcast_rob_id = rob_id_t'(2);
    alu_broadcast_reg_data = reg_data_t'(32'h77);
    @(negedge clk);
    chk("dep_b_issue_valid", 64'(iiq_issue_valid), 64'd1);
    chk("dep_b_issue_rob", 64'(iiq_issue_data.instr_rob_id), 64'd4);
    chk("dep_b_src1_bypass", 64'(iiq_issue_data.src1_data), 64'h77);
    nxt();
    alu_broadcast_valid = 1'b0;
    @(negedge clk);
    chk("dep_empty", 64'(iiq_issue_valid), 64'd0);

    // age order and full occupancy
    nxt();
    alu_issue_ready = 1'b0;
    iiq_dispatch_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      iiq_dispatch_data = mk(r, 1, 1, 1, 0, r, 0, 0, 0, 0);
      nxt();
    end
    iiq_dispatch_data = mk(15, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_dispatch_ready0", 64'(iiq_dispatch_ready), 64'd0);
    chk("full_head_rob", 64'(iiq_issue_data.instr_rob_id), 64'd0);
    nxt();
    @(negedge clk);
    chk("full_dispatch_ready1", 64'(iiq_dispatch_ready), 64'd0);
    nxt();
    iiq_dispatch_valid = 1'b0;
    alu_issue_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("age_issue_valid", 64'(iiq_issue_valid), 64'd1);
      chk("age_issue_rob", 64'(iiq_issue_data.instr_rob_id), 64'(k));
      if (k == 0) chk("age_ready_first", 64'(iiq_dispatch_ready), 64'd0);
      if (k == 1) chk("age_ready_after", 64'(iiq_dispatch_ready), 64'd1);
      nxt();
    end
    @(negedge clk);
    chk("age_drained", 64'(iiq_issue_valid), 64'd0);

    // load wakeup and capture
    nxt();
    iiq_dispatch_valid = 1'b1;
    iiq_dispatch_data = mk(10, 1, 0, 0, 0, 0, 1, 0, 9, 0);
    nxt();
    iiq_dispatch_valid = 1'b0;
    ld_broadcast_valid = 1'b1;
    ld_broadcast_rob_id = rob_id_t'(9);
    ld_broadcast_reg_data = reg_data_t'(32'hDEAD);
    @(negedge clk);
    chk("ld_wait_no_issue", 64'(iiq_issue_valid), 64'd0);
    nxt();
    ld_broadcast_valid = 1'b0;
    @(negedge clk);
    chk("ld_issue_valid", 64'(iiq_issue_valid), 64'd1);
    chk("ld_issue_rob", 64'(iiq_issue_data.instr_rob_id), 64'd10);
    chk("ld_src2_data", 64'(iiq_issue_data.src2_data), 64'hDEAD);

    // flush with pending issue and dispatch
    nxt();
    alu_issue_ready = 1'b0;
    iiq_dispatch_valid = 1'b1;
    for (int r = 11; r < 16; r++) begin
      iiq_dispatch_data = mk(r, 1, 1, 1, 0, r, 0, 0, 0, 0);
      nxt();
    end
    iiq_dispatch_data = mk(20, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch_redirect_valid = 1'b1;
    alu_issue_ready = 1'b1;
    @(negedge clk);
    chk("flush_issue_valid", 64'(iiq_issue_valid), 64'd0);
    chk("flush_wakeup_valid", 64'(iiq_wakeup_valid), 64'd0);
    nxt();
    fetch_redirect_valid = 1'b0;
    iiq_dispatch_valid = 1'b0;
    @(negedge clk);
    chk("flush_after_valid", 64'(iiq_issue_valid), 64'd0);
    chk("flush_after_ready", 64'(iiq_dispatch_ready), 64'd1);
    chk("flush_after_count", 64'(dut.count), 64'd0);

    // asynchronous reset mid-cycle
    nxt();
    alu_issue_ready = 1'b0;
    iiq_dispatch_valid = 1'b1;
    for (int r = 21; r < 24; r++) begin
      iiq_dispatch_data = mk(r, 1, 1, 1, 0, r, 0, 0, 0, 0);
      nxt();
    end
    iiq_dispatch_valid = 1'b0;
    #2;
    chk("arst_before_valid", 64'(iiq_issue_valid), 64'd1);
    rst_aL = 1'b0;
    #1;
    chk("arst_issue_valid", 64'(iiq_issue_valid), 64'd0);
    chk("arst_count", 64'(dut.count), 64'd0);
    @(negedge clk);
    rst_aL = 1'b1;
    nxt();
    @(negedge clk);
    chk("arst_after_valid", 64'(iiq_issue_valid), 64'd0);
    chk("arst_after_ready", 64'(iiq_dispatch_ready), 64'd1);
    nxt();
    iiq_dispatch_valid = 1'b1;
    iiq_dispatch_data = mk(7, 0, 1, 1, 0, 42, 0, 0, 0, 0);
    alu_issue_ready = 1'b1;
    nxt();
    iiq_dispatch_valid = 1'b0;
    @(negedge clk);
    chk("arst_reuse_rob", 64'(iiq_issue_data.instr_rob_id), 64'd7);
    chk("arst_reuse_nowake", 64'(iiq_wakeup_valid), 64'd0);
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer issue queue (IIQ), directly downstream of dispatch, upstream of the ALU.
- Buffers renamed integer instructions (iiq_entry_t), tracks source readiness from wakeups and broadcasts, and captures source data.
- Each cycle, issues the oldest fully-ready entry to the ALU.
- On issue, emits the speculative wakeup that dispatch and queued entries consume.

Parameters:
- N_ENTRIES, 8, queue depth; power of two, at least 2.
- CNT_WIDTH, $clog2(N_ENTRIES)+1, occupancy counter width.

Ports:
- clk  in  1  clock.
- rst_aL  in  1  reset; asynchronous, active-low.
- iiq_dispatch_ready  out  1  free slot available.
- iiq_dispatch_valid  in  1  dispatch offers an entry.
- iiq_dispatch_data  in  iiq_entry_t  entry; ready/data fields already bypassed by dispatch.
- alu_issue_ready  in  1  ALU accepts an instruction this cycle.
- iiq_issue_valid  out  1  ready entry presented.
- iiq_issue_data  out  iiq_entry_t  selected entry, with same-cycle data bypass applied.
- iiq_wakeup_valid  out  1  issued instruction writes rd.
- iiq_wakeup_rob_id  out  rob_id_t  tag of issued instruction.
- alu_broadcast_valid  in  1  ALU result valid.
- alu_broadcast_rob_id  in  rob_id_t  ALU result tag.
- alu_broadcast_reg_data  in  reg_data_t  ALU result.
- ld_broadcast_valid  in  1  load result valid.
- ld_broadcast_rob_id  in  rob_id_t  load result tag.
- ld_broadcast_reg_data  in  reg_data_t  load result.
- fetch_redirect_valid  in  1  flush all entries.

Behaviour:
- Storage and reset:
  - Compacting array of N_ENTRIES slots; slot 0 is the oldest. Per-slot valid bit; occupancy count.
  - rst_aL low (asynchronous): all valid bits = 0, count = 0.
  - Outputs in reset: iiq_dispatch_ready = 1, iiq_issue_valid = 0, iiq_wakeup_valid = 0, iiq_issue_data = '0, iiq_wakeup_rob_id = '0.
- Dispatch:
  - iiq_dispatch_ready = (count < N_ENTRIES). A freed slot is not reused in the same cycle.
  - dispatch_fire = valid & ready & ~fetch_redirect_valid.
  - The entry is written at slot (count - issue_fire) on the next edge.
- Readiness:
  - An entry is ready when valid & (~src1_valid | src1_ready) & (~src2_valid | src2_ready).
- Select and issue:
  - Selection picks the lowest-index ready slot (combinational find-first).
  - iiq_issue_valid = any ready & ~fetch_redirect_valid.
  - issue_fire = iiq_issue_valid & alu_issue_ready.
  - Zero-cycle latency from ready to issue_valid.
- Collapse:
  - On issue_fire, slots above the issued index shift down by one at the next edge.
  - count_next = count - issue_fire + dispatch_fire.
  - Simultaneous issue and dispatch at full occupancy cannot occur, because ready = 0 when full.
- Wakeup:
  - iiq_wakeup_valid = issue_fire & dst_valid; iiq_wakeup_rob_id = instr_rob_id. Same cycle as the issue.
  - At the next edge, every valid entry with a matching srcN_rob_id (and srcN_valid) sets srcN_ready. Data is not yet captured.
- ALU timing:
  - The ALU broadcasts an instruction issued at cycle t during cycle t+1. A consumer woken at t can therefore issue at t+1.
- Data capture and bypass:
  - At each edge, each matching src with alu_broadcast_valid or ld_broadcast_valid captures the data.
  - ld_broadcast_valid also sets srcN_ready.
  - iiq_issue_data srcN_data is muxed with priority: ALU broadcast match, then load broadcast match, then stored data.
- Simultaneous events:
  - Wakeup, capture, and collapse apply together; an entry that shifts keeps its updated fields.
  - A dispatched entry is not compared against same-cycle broadcasts, because dispatch already bypassed them.
- Flush:
  - fetch_redirect_valid: at the next edge all valid bits = 0 and count = 0.
  - In that cycle, issue_valid and wakeup are forced 0 and dispatch is dropped.
- Mid-operation reset clears the queue immediately; no partial state survives.

Decomposition:
- Shared package (global_defs): iiq_entry_t, rob_id_t, reg_data_t, addr_t, `ROB_ID_WIDTH, `REG_DATA_WIDTH.
- Sub-module iiq_select: N-bit ready vector in; onehot grant, binary index and any-valid out.
- The compaction shift, wakeup comparators, and bypass muxes stay in int_issue_queue.

Test Plan:
- Basic issue:
  - Stimulus: dispatch one entry with src1 ready, src1_data=5, src2_valid=0, dst_valid=1, rob_id=3; alu_issue_ready=1.
  - Response: issue_valid the next cycle; iiq_wakeup_valid=1, rob_id=3 in that same cycle; count returns to 0.
- Back-to-back dependence:
  - Stimulus: A (rob 2) ready; B with src1_rob_id=2 not ready. A issues at t; ALU broadcasts rob 2 with data 0x77 at t+1.
  - Response: B issues at t+1 with src1_data=0x77 via bypass.
- Age order:
  - Stimulus: fill 8 entries with rob ids 0-7, all ready; hold alu_issue_ready=0 for 2 cycles, then 1.
  - Response: iiq_dispatch_ready=0 while full; issue order 0,1,...,7; dispatch_ready returns to 1 one cycle after the first issue.
- Load wakeup:
  - Stimulus: entry waiting on src2 rob 9; ld_broadcast rob 9 with data 0xDEAD.
  - Response: the entry issues the following cycle with src2_data=0xDEAD.
- Flush:
  - Stimulus: 5 entries queued; assert fetch_redirect_valid while issue_valid would be 1 and dispatch_valid=1.
  - Response: no issue and no wakeup that cycle; next cycle count=0, issue_valid=0, dispatch_ready=1.
- Async reset:
  - Stimulus: pull rst_aL low mid-cycle with 3 entries queued.
  - Response: issue_valid drops to 0 immediately, and the queue is empty after release.
